// File: rtl/timer_multi_prescaled_if.sv
// timer_multi_prescaled_if: control/status bundle of the multi-channel prescaled timer
// Ports: ch_en/ch_clr/ch_mode/ch_cmp/read/ovf_clr driven by master;
//        count_out/match/ovf/tock driven by slave (the timer).
interface timer_multi_prescaled_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_clr;
  logic [2*NUM_CH-1:0]     ch_mode;
  logic [NUM_CH*CNT_W-1:0] ch_cmp;
  logic                    read;
  logic [NUM_CH-1:0]       ovf_clr;
  logic [NUM_CH*CNT_W-1:0] count_out;
  logic [NUM_CH-1:0]       match;
  logic [NUM_CH-1:0]       ovf;
  logic                    tock;
  modport master (
    output ch_en, ch_clr, ch_mode, ch_cmp, read, ovf_clr,
    input  count_out, match, ovf, tock
  );
  modport slave (
    input  ch_en, ch_clr, ch_mode, ch_cmp, read, ovf_clr,
    output count_out, match, ovf, tock
  );
endinterface

// File: rtl/timer_multi_prescaled.sv
// timer_multi_prescaled: shared prescaler driving NUM_CH counters with free-run/periodic/one-shot modes
// Ports: clk (system clock), reset (sync, active-low), bus (slave side of timer_multi_prescaled_if:
//        per-channel enable/clear/mode/compare, snapshot read, overflow clear in;
//        snapshot count_out, match pulses, sticky ovf, tock out).
module timer_multi_prescaled #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 1250,
  parameter int DIV_W    = 11
) (
  input logic clk,
  input logic reset,
  timer_multi_prescaled_if.slave bus
);
  logic [DIV_W-1:0]        div_cnt;
  logic                    tock_q;
  logic [NUM_CH-1:0]       match_q, match_d, ovf_q, ovf_d;
  logic [NUM_CH*CNT_W-1:0] count_q, cnt_all;
  logic                    div_end;
  assign div_end = div_cnt == DIV_W'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tock_q  <= 1'b0;
      match_q <= '0;
      ovf_q   <= '0;
      count_q <= '0;
    end else begin
      div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
      tock_q  <= div_end;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      if (bus.read) count_q <= cnt_all;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, cmp;
    logic [1:0]       mode;
    logic             done, hit, step, stop, wrap, clr;
    assign cmp  = bus.ch_cmp[CNT_W*i +: CNT_W];
    assign mode = bus.ch_mode[2*i +: 2];
    assign clr  = bus.ch_clr[i];
    assign hit  = cnt == cmp;
    assign step = tock_q && bus.ch_en[i] && !done;
    // periodic and one-shot both suppress the increment on a compare hit
    assign stop = hit && (mode == 2'b01 || mode == 2'b10);
    assign wrap = !clr && step && !stop && &cnt;
    assign match_d[i] = !clr && step && hit;
    // a fresh wrap beats a same-cycle clear request
    assign ovf_d[i] = wrap || (ovf_q[i] && !bus.ovf_clr[i]);
    assign cnt_all[CNT_W*i +: CNT_W] = cnt;
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (clr) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (step) begin
        cnt  <= stop ? (mode == 2'b01 ? '0 : cnt) : cnt + CNT_W'(1);
        done <= stop && mode == 2'b10;
      end
    end
  end
  assign bus.tock      = tock_q;
  assign bus.match     = match_q;
  assign bus.ovf       = ovf_q;
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_timer_multi_prescaled.sv
// tb_timer_multi_prescaled: directed checks of prescaler, channel modes, snapshot, ovf and reset
module tb_timer_multi_prescaled;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  timer_multi_prescaled_if #(.NUM_CH(2), .CNT_W(4)) bus ();
  timer_multi_prescaled #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(4), .DIV_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_tock();
    int n = 0;
    while (bus.tock !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (bus.tock !== 1'b1) begin
      tests++;
      fails++;
      $error("FAIL wait_tock: observed no tock expected tock within 8 cycles");
    end
  endtask
  task automatic tick();
    wait_tock();
    step();
  endtask
  task automatic snap();
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
  endtask
  initial begin
    bus.ch_en = '0; bus.ch_clr = '0; bus.ch_mode = '0; bus.ch_cmp = '0;
    bus.read = 1'b0; bus.ovf_clr = '0;
    repeat (3) step();
    reset = 1'b1;
    // 1: prescaler alone
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_tock_%0d", k), 32'(bus.tock), 32'(k % 4 == 0));
    end
    chk("t1_count_out", 32'(bus.count_out), 0);
    chk("t1_ovf", 32'(bus.ovf), 0);
    chk("t1_match", 32'(bus.match), 0);
    // 2: ch0 free-run, cmp 3
    bus.ch_cmp = 8'h03; bus.ch_en = 2'b01;
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk($sformatf("t2_match_%0d", j), 32'(bus.match[0]), 32'(j == 4));
      if (j == 4) begin
        step();
        chk("t2_match_width", 32'(bus.match[0]), 0);
      end
      if (j == 15) begin
        chk("t2_ovf_pre", 32'(bus.ovf), 0);
        snap();
        chk("t2_cnt15", 32'(bus.count_out[3:0]), 15);
      end
    end
    snap();
    chk("t2_wrap_cnt", 32'(bus.count_out[3:0]), 0);
    chk("t2_wrap_ovf", 32'(bus.ovf), 32'b01);
    tick();
    chk("t2_ovf_sticky", 32'(bus.ovf), 32'b01);
    bus.ovf_clr = 2'b01; step(); bus.ovf_clr = '0;
    chk("t2_ovf_clr", 32'(bus.ovf), 0);
    // 3: ch1 periodic, cmp 2
    bus.ch_en = 2'b10; bus.ch_mode = 4'b0100; bus.ch_cmp = 8'h23;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk($sformatf("t3_match_%0d", j), 32'(bus.match[1]), 32'(j % 3 == 0));
      snap();
      chk($sformatf("t3_cnt_%0d", j), 32'(bus.count_out[7:4]), 32'(j % 3));
    end
    chk("t3_ovf", 32'(bus.ovf), 0);
    // 4: ch0 one-shot, cmp 5
    bus.ch_clr = 2'b01; step(); bus.ch_clr = '0;
    bus.ch_mode = 4'b0110; bus.ch_cmp = 8'h25; bus.ch_en = 2'b01;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("t4_match_%0d", j), 32'(bus.match[0]), 32'(j == 6));
      snap();
      chk($sformatf("t4_cnt_%0d", j), 32'(bus.count_out[3:0]), 32'(j < 5 ? j : 5));
    end
    bus.ch_clr = 2'b01; step(); bus.ch_clr = '0;
    snap();
    chk("t4_clr_cnt", 32'(bus.count_out[3:0]), 0);
    tick();
    snap();
    chk("t4_resume", 32'(bus.count_out[3:0]), 1);
    // 5: read coincident with tock returns pre-update counts
    bus.ch_clr = 2'b11; step(); bus.ch_clr = '0;
    bus.ch_mode = 4'b0000; bus.ch_cmp = 8'hFF; bus.ch_en = 2'b11;
    repeat (7) tick();
    bus.ch_en = 2'b10;
    repeat (2) tick();
    bus.ch_en = 2'b11;
    wait_tock();
    snap();
    chk("t5_read_tock", 32'(bus.count_out), 32'h97);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 5 == 0) chk($sformatf("t5_hold_%0d", k), 32'(bus.count_out), 32'h97);
    end
    snap();
    chk("t5_after", 32'(bus.count_out), 32'hFD);
    // 6: mid-count reset, then clear together with tock
    bus.ch_en = 2'b10;
    tick();
    chk("t6_ovf1", 32'(bus.ovf), 32'b10);
    bus.ch_clr = 2'b11; step(); bus.ch_clr = '0;
    bus.ch_en = 2'b11;
    repeat (3) tick();
    bus.ch_en = 2'b01;
    repeat (3) tick();
    snap();
    chk("t6_pre_cnt", 32'(bus.count_out), 32'h36);
    chk("t6_pre_ovf", 32'(bus.ovf), 32'b10);
    bus.ch_en = '0;
    reset = 1'b0; step(); reset = 1'b1;
    chk("t6_rst_tock", 32'(bus.tock), 0);
    chk("t6_rst_match", 32'(bus.match), 0);
    chk("t6_rst_ovf", 32'(bus.ovf), 0);
    chk("t6_rst_cnt_out", 32'(bus.count_out), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_tock_%0d", k), 32'(bus.tock), 32'(k == 4));
    end
    snap();
    chk("t6_rst_counts", 32'(bus.count_out), 0);
    bus.ch_cmp = 8'hF0; bus.ch_en = 2'b01;
    wait_tock();
    bus.ch_clr = 2'b01; step(); bus.ch_clr = '0;
    chk("t6_clr_tock_match", 32'(bus.match), 0);
    snap();
    chk("t6_clr_tock_cnt", 32'(bus.count_out[3:0]), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
